jls_ctx_window: RTL and testbench

// - Parametrised JPEG-LS causal-context extractor; successor to the fixed 256x256, 16-bit neighbour/gradient stage.
// - Consumes a raster pixel stream and emits per pixel Rx, Ra, Rb, Rc, Rd, gradients D1..D3 and position flags.
// - Owns its previous-row line buffer; no external FIFO IP.
// - Sits between the pixel source and the context-modelling/prediction stage.

---
 rtl/jls_pkg.sv | 20 ++
 rtl/jls_line_buf.sv | 29 ++
 rtl/jls_ctx_window.sv | 210 +++++++++++++++++++++
 tb/tb_jls_ctx_window.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jls_pkg.sv
// Shared JPEG-LS definitions used by the context extractor and the context quantiser.
package jls_pkg;

  // Default pixel width for the JPEG-LS pipeline.
  localparam int JLS_DW_DEFAULT = 16;

  // Position of a pixel within its frame.
  typedef struct packed {
    logic first_row;
    logic first_col;
    logic last_col;
    logic last_pix;
  } jls_pos_flags_t;

  // A signed difference of two unsigned DW-bit pixels needs one extra bit.
  function automatic int grad_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/jls_line_buf.sv
// Previous-row line RAM: one write port and one combinational read port.
// The context stage reads one column ahead of the column it writes.
// The address space is rounded up to a power of two so that the address
// exactly covers the array. Entries at IMG_W and above are never addressed.
module jls_line_buf #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1 << IW) - 1];

  // Store the current pixel so that the next row sees it as its upper neighbour.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jls_ctx_window.sv
// JPEG-LS causal-context extractor: for each pixel of a raster stream it
// presents Rx, its neighbours Ra/Rb/Rc/Rd (with the T.87 edge rules applied),
// the gradients D1..D3 and the position flags, through one registered stage.
module jls_ctx_window
  import jls_pkg::*;
#(
  parameter int DW    = JLS_DW_DEFAULT,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int AW    = $clog2(IMG_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic [DW-1:0]         s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         Rx,
  output logic [DW-1:0]         Ra,
  output logic [DW-1:0]         Rb,
  output logic [DW-1:0]         Rc,
  output logic [DW-1:0]         Rd,
  output logic [grad_w(DW)-1:0] D1,
  output logic [grad_w(DW)-1:0] D2,
  output logic [grad_w(DW)-1:0] D3,
  output logic                  first_row,
  output logic                  first_col,
  output logic                  last_col,
  output logic                  last_pix
);

  localparam int GW = grad_w(DW);
  // The row counter is sized from IMG_H so that tall frames cannot overflow it.
  localparam int RW = $clog2(IMG_H) + 1;
  localparam int IW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam bit ONE_COL = (IMG_W == 1);

  logic           xfer;
  logic [AW-1:0]  col_q;
  logic [AW-1:0]  eff_col;
  logic [RW-1:0]  row_q;
  logic [RW-1:0]  eff_row;
  jls_pos_flags_t pos;
  jls_pos_flags_t flags_q;

  // Upper-row window: above_b_q is the pixel above the next input, above_c_q
  // the one above-left. left_q is the previous input pixel. col0_ra_q is the
  // Ra presented for the most recent column-0 pixel, which becomes Rc for the
  // column-0 pixel of the following row.
  logic [DW-1:0]  above_b_q;
  logic [DW-1:0]  above_c_q;
  logic [DW-1:0]  left_q;
  logic [DW-1:0]  col0_ra_q;

  logic [IW-1:0]  wr_addr;
  logic [IW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;

  logic [DW-1:0]  nb_a;
  logic [DW-1:0]  nb_b;
  logic [DW-1:0]  nb_c;
  logic [DW-1:0]  nb_d;
  logic [GW-1:0]  d1;
  logic [GW-1:0]  d2;
  logic [GW-1:0]  d3;

  assign s_ready = !m_valid || m_ready;
  assign xfer    = s_valid && s_ready;

  // Position of the pixel now on the input; start-of-frame forces (0,0).
  always_comb begin
    eff_col = col_q;
    eff_row = row_q;
    if (s_sof) begin
      eff_col = '0;
      eff_row = '0;
    end
    pos.first_row = (eff_row == '0);
    pos.first_col = (eff_col == '0);
    pos.last_col  = (eff_col == LAST_COL);
    pos.last_pix  = (eff_col == LAST_COL) && (eff_row == LAST_ROW);
  end

  // Write the current column and read one column ahead for Rd. At the end of
  // a row the read wraps to word 0, which already holds this row's first pixel
  // and is exactly the Rb of the next row's first pixel.
  always_comb begin
    wr_addr = eff_col[IW-1:0];
    rd_addr = '0;
    if (!pos.last_col) begin
      rd_addr = IW'(eff_col + AW'(1));
    end
  end

  jls_line_buf #(
    .DW    (DW),
    .DEPTH (IMG_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_addr),
    .wdata (s_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Neighbour selection with the edge rules; row 0 hides stale line-buffer data.
  always_comb begin
    nb_b = above_b_q;
    nb_a = left_q;
    nb_c = above_c_q;
    nb_d = rd_data;
    if (pos.first_row) begin
      nb_b = '0;
      nb_c = '0;
      nb_d = '0;
    end else begin
      if (pos.first_col) begin
        nb_c = col0_ra_q;
      end
      if (pos.last_col) begin
        nb_d = above_b_q;
      end
    end
    if (pos.first_col) begin
      nb_a = nb_b;
    end
    d1 = GW'(nb_d) - GW'(nb_b);
    d2 = GW'(nb_b) - GW'(nb_c);
    d3 = GW'(nb_c) - GW'(nb_a);
  end

  // Advance the raster position on every accepted pixel, wrapping at row and frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (xfer) begin
      if (pos.last_col) begin
        col_q <= '0;
        row_q <= pos.last_pix ? '0 : eff_row + RW'(1);
      end else begin
        col_q <= eff_col + AW'(1);
        row_q <= eff_row;
      end
    end
  end

  // Slide the upper-row window along the row and reload it at the row wrap.
  // With a single column the line RAM is read and written at the same word,
  // so the next row's upper pixel is taken straight from the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      above_b_q <= '0;
      above_c_q <= '0;
      left_q    <= '0;
      col0_ra_q <= '0;
    end else if (xfer) begin
      left_q <= s_data;
      if (pos.first_col) begin
        col0_ra_q <= nb_a;
      end
      if (pos.last_col) begin
        above_b_q <= ONE_COL ? s_data : rd_data;
      end else begin
        above_c_q <= above_b_q;
        above_b_q <= rd_data;
      end
    end
  end

  // Output stage: load on transfer, hold while the consumer stalls, drop valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      Rx      <= '0;
      Ra      <= '0;
      Rb      <= '0;
      Rc      <= '0;
      Rd      <= '0;
      D1      <= '0;
      D2      <= '0;
      D3      <= '0;
      flags_q <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      Rx      <= s_data;
      Ra      <= nb_a;
      Rb      <= nb_b;
      Rc      <= nb_c;
      Rd      <= nb_d;
      D1      <= d1;
      D2      <= d2;
      D3      <= d3;
      flags_q <= pos;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  assign first_row = flags_q.first_row;
  assign first_col = flags_q.first_col;
  assign last_col  = flags_q.last_col;
  assign last_pix  = flags_q.last_pix;

endmodule

// File: tb/tb_jls_ctx_window.sv
// Testbench for jls_ctx_window: a 4x3 8-bit ramp instance driven from a
// vector table (plain, backpressured, back-to-back, resync, reset), a 16-bit
// instance for gradient extremes and a single-column instance.
module tb_jls_ctx_window;

  typedef struct {
    logic       sof;
    logic [7:0] rx;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rc;
    logic [7:0] rd;
    logic [3:0] flags;   // {first_row, first_col, last_col, last_pix}
  } vec_t;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;

  vec_t tab[$];

  // Instance A: DW=8, 4x3
  logic       a_s_valid, a_s_ready, a_s_sof, a_m_valid, a_m_ready;
  logic [7:0] a_s_data, a_rx, a_ra, a_rb, a_rc, a_rd;
  logic [8:0] a_d1, a_d2, a_d3;
  logic       a_fr, a_fc, a_lc, a_lp;
  logic [70:0] a_outs;

  // Instance B: DW=16, 4x3
  logic        b_s_valid, b_s_ready, b_s_sof, b_m_valid, b_m_ready;
  logic [15:0] b_s_data, b_rx, b_ra, b_rb, b_rc, b_rd;
  logic [16:0] b_d1, b_d2, b_d3;
  logic        b_fr, b_fc, b_lc, b_lp;

  // Instance C: DW=8, 1x4
  logic       c_s_valid, c_s_ready, c_s_sof, c_m_valid, c_m_ready;
  logic [7:0] c_s_data, c_rx, c_ra, c_rb, c_rc, c_rd;
  logic [8:0] c_d1, c_d2, c_d3;
  logic       c_fr, c_fc, c_lc, c_lp;

  assign a_outs = {a_rx, a_ra, a_rb, a_rc, a_rd, a_d1, a_d2, a_d3, a_fr, a_fc, a_lc, a_lp};

  jls_ctx_window #(.DW(8), .IMG_W(4), .IMG_H(3)) dut_a (
    .clk(clk), .rst(rst),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_sof(a_s_sof), .s_data(a_s_data),
    .m_valid(a_m_valid), .m_ready(a_m_ready),
    .Rx(a_rx), .Ra(a_ra), .Rb(a_rb), .Rc(a_rc), .Rd(a_rd),
    .D1(a_d1), .D2(a_d2), .D3(a_d3),
    .first_row(a_fr), .first_col(a_fc), .last_col(a_lc), .last_pix(a_lp)
  );

  jls_ctx_window #(.DW(16), .IMG_W(4), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_sof(b_s_sof), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready),
    .Rx(b_rx), .Ra(b_ra), .Rb(b_rb), .Rc(b_rc), .Rd(b_rd),
    .D1(b_d1), .D2(b_d2), .D3(b_d3),
    .first_row(b_fr), .first_col(b_fc), .last_col(b_lc), .last_pix(b_lp)
  );

  jls_ctx_window #(.DW(8), .IMG_W(1), .IMG_H(4)) dut_c (
    .clk(clk), .rst(rst),
    .s_valid(c_s_valid), .s_ready(c_s_ready), .s_sof(c_s_sof), .s_data(c_s_data),
    .m_valid(c_m_valid), .m_ready(c_m_ready),
    .Rx(c_rx), .Ra(c_ra), .Rb(c_rb), .Rc(c_rc), .Rd(c_rd),
    .D1(c_d1), .D2(c_d2), .D3(c_d3),
    .first_row(c_fr), .first_col(c_fc), .last_col(c_lc), .last_pix(c_lp)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a line when it does not match.
  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Comparison that cannot be expressed as a value match (timeout, extra output).
  task automatic failNow(input string msg);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s", msg);
  endtask

  task automatic addVec(input logic sof, input logic [7:0] rx, input logic [7:0] ra,
                        input logic [7:0] rb, input logic [7:0] rc, input logic [7:0] rd,
                        input logic [3:0] fl);
    vec_t v;
    v.sof = sof; v.rx = rx; v.ra = ra; v.rb = rb; v.rc = rc; v.rd = rd; v.flags = fl;
    tab.push_back(v);
  endtask

  // Ramp frame, pixel = row*16 + col, expectations worked out by hand.
  task automatic addRampFrame();
    addVec(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1100);
    addVec(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000);
    addVec(0, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1000);
    addVec(0, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00, 4'b1010);
    addVec(0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 4'b0100);
    addVec(0, 8'h11, 8'h10, 8'h01, 8'h00, 8'h02, 4'b0000);
    addVec(0, 8'h12, 8'h11, 8'h02, 8'h01, 8'h03, 4'b0000);
    addVec(0, 8'h13, 8'h12, 8'h03, 8'h02, 8'h03, 4'b0010);
    addVec(0, 8'h20, 8'h10, 8'h10, 8'h00, 8'h11, 4'b0100);
    addVec(0, 8'h21, 8'h20, 8'h11, 8'h10, 8'h12, 4'b0000);
    addVec(0, 8'h22, 8'h21, 8'h12, 8'h11, 8'h13, 4'b0000);
    addVec(0, 8'h23, 8'h22, 8'h13, 8'h12, 8'h13, 4'b0011);
  endtask

  // Compare instance A's outputs with one table record; gradients follow from the expected neighbours.
  task automatic checkOutput(input vec_t v, input string tag);
    logic [8:0] e1, e2, e3;
    e1 = {1'b0, v.rd} - {1'b0, v.rb};
    e2 = {1'b0, v.rb} - {1'b0, v.rc};
    e3 = {1'b0, v.rc} - {1'b0, v.ra};
    checkVal({tag, " Rx"}, a_rx, v.rx);
    checkVal({tag, " Ra"}, a_ra, v.ra);
    checkVal({tag, " Rb"}, a_rb, v.rb);
    checkVal({tag, " Rc"}, a_rc, v.rc);
    checkVal({tag, " Rd"}, a_rd, v.rd);
    checkVal({tag, " D1"}, a_d1, e1);
    checkVal({tag, " D2"}, a_d2, e2);
    checkVal({tag, " D3"}, a_d3, e3);
    checkVal({tag, " flags"}, {a_fr, a_fc, a_lc, a_lp}, v.flags);
  endtask

  // Stream tab[first .. first+n-1] into instance A, optionally toggling m_ready
  // every cycle, and match each consumed output in order against the table.
  // While the output is stalled it must stay unchanged.
  task automatic applyStimulus(input int first, input int n, input bit bp);
    vec_t exp_q[$];
    vec_t v;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [70:0] snap = '0;
    while (got < n && cyc < n * 4 + 20) begin
      if (sent < n) begin
        a_s_valid = 1'b1;
        a_s_sof   = tab[first + sent].sof;
        a_s_data  = tab[first + sent].rx;
      end else begin
        a_s_valid = 1'b0;
        a_s_sof   = 1'b0;
        a_s_data  = '0;
      end
      a_m_ready = bp ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (stalled) begin
        checkVal($sformatf("hold v%0d", first + got), a_outs, snap);
      end
      if (a_m_valid && a_m_ready) begin
        if (exp_q.size() == 0) begin
          failNow($sformatf("unexpected output after v%0d: got extra pixel 0x%0h", first + got, a_rx));
        end else begin
          v = exp_q.pop_front();
          checkOutput(v, $sformatf("v%0d", first + got));
          got++;
        end
      end
      stalled = a_m_valid && !a_m_ready;
      snap    = a_outs;
      if (a_s_valid && a_s_ready) begin
        exp_q.push_back(tab[first + sent]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (got < n) begin
      failNow($sformatf("timeout: got %0d outputs, expected %0d", got, n));
    end
    a_s_valid = 1'b0;
    a_s_sof   = 1'b0;
    a_m_ready = 1'b1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One pixel into instance B (m_ready is held high, so it is always accepted).
  task automatic driveB(input logic [15:0] d);
    b_s_valid = 1'b1;
    b_s_data  = d;
    @(posedge clk);
    #1;
    b_s_valid = 1'b0;
  endtask

  // One pixel into instance C, then check its context.
  task automatic driveCheckC(input logic [7:0] d, input logic [7:0] ra, input logic [7:0] rb,
                             input logic [7:0] rc, input logic [7:0] rd, input logic [3:0] fl,
                             input string tag);
    c_s_valid = 1'b1;
    c_s_data  = d;
    @(posedge clk);
    #1;
    c_s_valid = 1'b0;
    checkVal({tag, " m_valid"}, c_m_valid, 1'b1);
    checkVal({tag, " Rx"}, c_rx, d);
    checkVal({tag, " Ra"}, c_ra, ra);
    checkVal({tag, " Rb"}, c_rb, rb);
    checkVal({tag, " Rc"}, c_rc, rc);
    checkVal({tag, " Rd"}, c_rd, rd);
    checkVal({tag, " flags"}, {c_fr, c_fc, c_lc, c_lp}, fl);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    a_s_valid = 1'b0; a_s_sof = 1'b0; a_s_data = '0; a_m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_sof = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
    c_s_valid = 1'b0; c_s_sof = 1'b0; c_s_data = '0; c_m_ready = 1'b1;

    // Vector table: two ramp frames (0..23), resync sequence (24..35), post-reset pixel (36).
    addRampFrame();
    addRampFrame();
    addVec(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1100);
    addVec(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000);
    addVec(0, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1000);
    addVec(0, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00, 4'b1010);
    addVec(0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 4'b0100);
    addVec(0, 8'h11, 8'h10, 8'h01, 8'h00, 8'h02, 4'b0000);
    addVec(1, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1100);
    addVec(0, 8'h13, 8'h12, 8'h00, 8'h00, 8'h00, 4'b1000);
    addVec(0, 8'h20, 8'h13, 8'h00, 8'h00, 8'h00, 4'b1000);
    addVec(0, 8'h21, 8'h20, 8'h00, 8'h00, 8'h00, 4'b1010);
    addVec(0, 8'h30, 8'h12, 8'h12, 8'h00, 8'h13, 4'b0100);
    addVec(0, 8'h31, 8'h30, 8'h13, 8'h12, 8'h20, 4'b0000);
    addVec(0, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1100);

    // Reset state of all three instances.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("reset A m_valid", a_m_valid, 1'b0);
    checkVal("reset A outputs", a_outs, '0);
    checkVal("reset B m_valid", b_m_valid, 1'b0);
    checkVal("reset C m_valid", c_m_valid, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] ramp frame, m_ready=1");
    applyStimulus(0, 12, 1'b0);

    $display("[TB] ramp frame, m_ready toggling");
    applyStimulus(0, 12, 1'b1);

    $display("[TB] back-to-back frames");
    applyStimulus(0, 24, 1'b0);

    $display("[TB] start-of-frame resync at (1,2)");
    applyStimulus(24, 12, 1'b0);

    // Reset while the output holds pixel (1,1) under a stall.
    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(0, 5, 1'b0);
    a_m_ready = 1'b0;
    a_s_valid = 1'b1;
    a_s_data  = 8'h11;
    @(posedge clk);
    #1;
    a_s_valid = 1'b0;
    @(negedge clk);
    checkVal("pre-reset m_valid", a_m_valid, 1'b1);
    checkVal("pre-reset Rx", a_rx, 8'h11);
    checkVal("pre-reset Ra", a_ra, 8'h10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_m_ready = 1'b1;
    @(negedge clk);
    checkVal("post-reset m_valid", a_m_valid, 1'b0);
    checkVal("post-reset Rx", a_rx, 8'h00);
    @(posedge clk);
    #1;
    applyStimulus(36, 1, 1'b0);

    // 16-bit extremes: row 0 all 0xFFFF, then zeros in row 1.
    $display("[TB] 16-bit gradient extremes");
    repeat (4) driveB(16'hFFFF);
    driveB(16'h0000);
    checkVal("ext (1,0) Ra", b_ra, 16'hFFFF);
    checkVal("ext (1,0) Rc", b_rc, 16'h0000);
    checkVal("ext (1,0) Rd", b_rd, 16'hFFFF);
    checkVal("ext (1,0) D1", b_d1, 17'h00000);
    checkVal("ext (1,0) D3", b_d3, 17'h10001);
    driveB(16'h0000);
    checkVal("ext (1,1) m_valid", b_m_valid, 1'b1);
    checkVal("ext (1,1) Ra", b_ra, 16'h0000);
    checkVal("ext (1,1) Rb", b_rb, 16'hFFFF);
    checkVal("ext (1,1) Rc", b_rc, 16'hFFFF);
    checkVal("ext (1,1) D2", b_d2, 17'h00000);
    checkVal("ext (1,1) D3", b_d3, 17'h0FFFF);

    // Single-column frame: every pixel is both first and last column.
    $display("[TB] single-column frame");
    driveCheckC(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1110, "w1 (0,0)");
    driveCheckC(8'h20, 8'h10, 8'h10, 8'h00, 8'h10, 4'b0110, "w1 (1,0)");
    driveCheckC(8'h30, 8'h20, 8'h20, 8'h10, 8'h20, 4'b0110, "w1 (2,0)");
    driveCheckC(8'h40, 8'h30, 8'h30, 8'h20, 8'h30, 4'b0111, "w1 (3,0)");
    driveCheckC(8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1110, "w1 next (0,0)");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
